// File: rtl/afu_mmio_responder_if.sv
// PSL-side MMIO bundle: one-cycle request strobe in, one-cycle acknowledge with read data out.
// Odd parity travels with address and data in both directions.
interface afu_mmio_responder_if #(
  parameter int MMIO_ADDR_W = 24
);
  logic                   mmio_in_valid;
  logic                   mmio_in_read;
  logic                   mmio_in_dw;
  logic [MMIO_ADDR_W-1:0] mmio_in_addr;
  logic                   mmio_in_addrpar;
  logic [63:0]            mmio_in_data;
  logic                   mmio_in_datapar;
  logic                   mmio_out_ack;
  logic [63:0]            mmio_out_data;
  logic                   mmio_out_datapar;

  modport master (
    output mmio_in_valid, mmio_in_read, mmio_in_dw, mmio_in_addr,
           mmio_in_addrpar, mmio_in_data, mmio_in_datapar,
    input  mmio_out_ack, mmio_out_data, mmio_out_datapar
  );

  modport slave (
    input  mmio_in_valid, mmio_in_read, mmio_in_dw, mmio_in_addr,
           mmio_in_addrpar, mmio_in_data, mmio_in_datapar,
    output mmio_out_ack, mmio_out_data, mmio_out_datapar
  );
endinterface

// File: rtl/afu_mmio_responder.sv
// MMIO decode of ALGO_REQUEST / ALGO_STATUS / ERROR_REG; define MMIO_PARITY_EN to check and generate odd parity.
// Ack two cycles after mmio_in_valid; no backpressure, a request arriving while busy is dropped and flags ERROR_REG[63].
module afu_mmio_responder #(
  parameter int                     MMIO_ADDR_W       = 24,
  parameter logic [MMIO_ADDR_W-1:0] ALGO_STATUS_ADDR  = 24'hFFFFFE,
  parameter logic [MMIO_ADDR_W-1:0] ALGO_REQUEST_ADDR = 24'hFFFFFC,
  parameter logic [MMIO_ADDR_W-1:0] ERROR_REG_ADDR    = 24'hFFFFFA
) (
  input  logic                clock,
  input  logic                rstn,
  afu_mmio_responder_if.slave mmio,
  input  logic [63:0]         algo_status_in,
  input  logic                algo_status_valid,
  input  logic [63:0]         error_in,
  input  logic                error_valid,
  output logic [63:0]         algo_request_out,
  output logic                algo_request_valid
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ACK} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_read;
  logic                   r_dw;
  logic [MMIO_ADDR_W-1:0] r_addr;
  logic [63:0]            r_data;
  logic [63:0]            r_status;
  logic [63:0]            r_req;
  logic [63:0]            r_err;
  logic [63:0]            r_rdata;
  logic                   r_req_pulse;

  logic                   w_decode;
  logic                   w_par_err;
  logic                   w_overlap;
  logic                   w_wr_ok;
  logic                   w_req_wr;
  logic                   w_err_wr;
  logic [63:0]            w_sel;
  logic [31:0]            w_word;
  logic [63:0]            w_rdata;
  logic [63:0]            w_lane;
  logic [63:0]            w_lane_mask;
  logic [63:0]            w_req_next;
  logic [63:0]            w_err_clr;
  logic [63:0]            w_err_set;
  logic                   w_unused_err;

  // 32-bit accesses address either half of a register, so the LSB is ignored for the match.
  function automatic logic addr_hit(input logic [MMIO_ADDR_W-1:0] a, input logic dw,
                                    input logic [MMIO_ADDR_W-1:0] base);
    addr_hit = dw ? (a == base) : (a[MMIO_ADDR_W-1:1] == base[MMIO_ADDR_W-1:1]);
  endfunction

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (mmio.mmio_in_valid) w_next = S_DECODE;
      S_DECODE: w_next = S_ACK;
      S_ACK:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mmio.mmio_out_ack     = 1'b0;
    mmio.mmio_out_data    = 64'h0;
    mmio.mmio_out_datapar = 1'b0;
    if (r_state == S_ACK) begin
      mmio.mmio_out_ack  = 1'b1;
      mmio.mmio_out_data = r_rdata;
`ifdef MMIO_PARITY_EN
      mmio.mmio_out_datapar = ~^r_rdata;
`endif
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_read <= 1'b0;
      r_dw   <= 1'b0;
      r_addr <= '0;
      r_data <= 64'h0;
    end else if (r_state == S_IDLE && mmio.mmio_in_valid) begin
      r_read <= mmio.mmio_in_read;
      r_dw   <= mmio.mmio_in_dw;
      r_addr <= mmio.mmio_in_addr;
      r_data <= mmio.mmio_in_data;
    end
  end

`ifdef MMIO_PARITY_EN
  logic r_addrpar;
  logic r_datapar;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_addrpar <= 1'b0;
      r_datapar <= 1'b0;
    end else if (r_state == S_IDLE && mmio.mmio_in_valid) begin
      r_addrpar <= mmio.mmio_in_addrpar;
      r_datapar <= mmio.mmio_in_datapar;
    end
  end

  assign w_par_err = (r_addrpar != ~^r_addr) || (!r_read && (r_datapar != ~^r_data));
`else
  logic w_unused_par;
  assign w_unused_par = ^{mmio.mmio_in_addrpar, mmio.mmio_in_datapar};
  assign w_par_err    = 1'b0;
`endif

  assign w_decode  = (r_state == S_DECODE);
  assign w_overlap = mmio.mmio_in_valid && (r_state != S_IDLE);
  assign w_wr_ok   = w_decode && !r_read && !w_par_err;
  assign w_req_wr  = w_wr_ok && addr_hit(r_addr, r_dw, ALGO_REQUEST_ADDR);
  assign w_err_wr  = w_wr_ok && addr_hit(r_addr, r_dw, ERROR_REG_ADDR);

  always_comb begin
    w_sel = 64'h0;
    if (addr_hit(r_addr, r_dw, ALGO_STATUS_ADDR))       w_sel = r_status;
    else if (addr_hit(r_addr, r_dw, ALGO_REQUEST_ADDR)) w_sel = r_req;
    else if (addr_hit(r_addr, r_dw, ERROR_REG_ADDR))    w_sel = r_err;
    w_word  = r_addr[0] ? w_sel[63:32] : w_sel[31:0];
    w_rdata = 64'h0;
    if (r_read && !w_par_err) w_rdata = r_dw ? w_sel : {w_word, w_word};
  end

  // A 32-bit write always carries its payload in data[31:0]; steer it onto the addressed half.
  assign w_lane      = r_dw ? r_data : (r_addr[0] ? {r_data[31:0], 32'h0} : {32'h0, r_data[31:0]});
  assign w_lane_mask = r_dw ? {64{1'b1}} : (r_addr[0] ? {{32{1'b1}}, 32'h0} : {32'h0, {32{1'b1}}});
  assign w_req_next  = (r_req & ~w_lane_mask) | w_lane;
  assign w_err_clr   = w_err_wr ? w_lane : 64'h0;
  assign w_err_set   = {w_overlap, w_decode && w_par_err, error_valid ? error_in[61:0] : 62'h0};
  assign w_unused_err = ^error_in[63:62];

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_status    <= 64'h0;
      r_req       <= 64'h0;
      r_err       <= 64'h0;
      r_rdata     <= 64'h0;
      r_req_pulse <= 1'b0;
    end else begin
      if (algo_status_valid) r_status <= algo_status_in;
      if (w_req_wr)          r_req    <= w_req_next;
      // Set is applied after clear so a coincident set wins.
      r_err       <= (r_err & ~w_err_clr) | w_err_set;
      r_rdata     <= w_decode ? w_rdata : 64'h0;
      r_req_pulse <= w_req_wr;
    end
  end

  assign algo_request_out   = r_req;
  assign algo_request_valid = r_req_pulse;

endmodule

// File: tb/tb_afu_mmio_responder.sv
// Randomized bench for afu_mmio_responder: a register-level model predicts each ack, a monitor compares.
`timescale 1ns/1ps
module tb_afu_mmio_responder;
  localparam logic [23:0] A_STATUS = 24'hFFFFFE;
  localparam logic [23:0] A_REQ    = 24'hFFFFFC;
  localparam logic [23:0] A_ERR    = 24'hFFFFFA;

  logic        clock = 1'b0;
  logic        rstn  = 1'b0;
  logic [63:0] algo_status_in;
  logic        algo_status_valid;
  logic [63:0] error_in;
  logic        error_valid;
  logic [63:0] algo_request_out;
  logic        algo_request_valid;

  always #5 clock = ~clock;

  afu_mmio_responder_if #(.MMIO_ADDR_W(24)) mmio_bus ();

  afu_mmio_responder dut (
    .clock              (clock),
    .rstn               (rstn),
    .mmio               (mmio_bus),
    .algo_status_in     (algo_status_in),
    .algo_status_valid  (algo_status_valid),
    .error_in           (error_in),
    .error_valid        (error_valid),
    .algo_request_out   (algo_request_out),
    .algo_request_valid (algo_request_valid)
  );

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic        pulse;
    logic [63:0] req;
    logic        par;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Stimulus for the upcoming clock edge
  logic        d_rst = 1'b0;
  logic        d_valid, d_read, d_dw, d_apar, d_dpar, d_sv, d_ev;
  logic [23:0] d_addr;
  logic [63:0] d_data, d_sin, d_ein;

  // Reference model: register contents plus the request currently being decoded
  logic [63:0] m_status = 0, m_req = 0, m_err = 0;
  logic        p1 = 0, p2 = 0;
  logic        pd_read, pd_dw, pd_apar, pd_dpar;
  logic [23:0] pd_addr;
  logic [63:0] pd_data;

  function automatic int reg_index(input logic [23:0] a, input logic dw);
    logic [23:0] base;
    base = dw ? a : {a[23:1], 1'b0};
    if (base == A_STATUS) return 0;
    if (base == A_REQ)    return 1;
    if (base == A_ERR)    return 2;
    return -1;
  endfunction

  task automatic model_step();
    logic [63:0] set, clr, nreq, rd, full;
    logic        pulse, perr, acc;
    int          idx;
    exp_t        e;
    if (!d_rst) begin
      m_status = 0; m_req = 0; m_err = 0; p1 = 0; p2 = 0;
      return;
    end
    set = 0; clr = 0; nreq = m_req; pulse = 0;
    if (p1) begin
      perr = 1'b0;
`ifdef MMIO_PARITY_EN
      perr = (pd_apar != ~^pd_addr) || (!pd_read && (pd_dpar != ~^pd_data));
`endif
      idx  = reg_index(pd_addr, pd_dw);
      full = (idx == 0) ? m_status : (idx == 1) ? m_req : (idx == 2) ? m_err : 64'h0;
      rd   = 0;
      if (pd_read && !perr)
        rd = pd_dw ? full : (pd_addr[0] ? {2{full[63:32]}} : {2{full[31:0]}});
      if (!pd_read && !perr) begin
        if (idx == 1) begin
          pulse = 1'b1;
          if (pd_dw)           nreq = pd_data;
          else if (pd_addr[0]) nreq[63:32] = pd_data[31:0];
          else                 nreq[31:0]  = pd_data[31:0];
        end
        if (idx == 2) begin
          if (pd_dw)           clr = pd_data;
          else if (pd_addr[0]) clr[63:32] = pd_data[31:0];
          else                 clr[31:0]  = pd_data[31:0];
        end
      end
      if (perr) set[62] = 1'b1;
      e.cyc = cyc + 1; e.data = rd; e.pulse = pulse; e.req = nreq; e.par = 1'b0;
`ifdef MMIO_PARITY_EN
      e.par = ~^rd;
`endif
      q.push_back(e);
    end
    acc = 1'b0;
    if (d_valid) begin
      if (p1 || p2) set[63] = 1'b1;
      else begin
        acc = 1'b1;
        pd_read = d_read; pd_dw = d_dw; pd_addr = d_addr; pd_data = d_data;
        pd_apar = d_apar; pd_dpar = d_dpar;
      end
    end
    if (d_ev) set[61:0] = set[61:0] | d_ein[61:0];
    m_err = (m_err & ~clr) | set;
    m_req = nreq;
    if (d_sv) m_status = d_sin;
    p2 = p1;
    p1 = acc;
  endtask

  task automatic drive_cycle();
    @(negedge clock);
    rstn                     = d_rst;
    mmio_bus.mmio_in_valid   = d_valid;
    mmio_bus.mmio_in_read    = d_read;
    mmio_bus.mmio_in_dw      = d_dw;
    mmio_bus.mmio_in_addr    = d_addr;
    mmio_bus.mmio_in_addrpar = d_apar;
    mmio_bus.mmio_in_data    = d_data;
    mmio_bus.mmio_in_datapar = d_dpar;
    algo_status_valid        = d_sv;
    algo_status_in           = d_sin;
    error_valid              = d_ev;
    error_in                 = d_ein;
    model_step();
  endtask

  task automatic clear_drive();
    d_valid = 0; d_read = 0; d_dw = 0; d_addr = 0; d_data = 0; d_apar = 0; d_dpar = 0;
    d_sv = 0; d_sin = 0; d_ev = 0; d_ein = 0;
  endtask

  // badpar: 0 good, 1 corrupt address parity, 2 corrupt data parity
  task automatic set_req(input logic rd, input logic dw, input logic [23:0] a,
                         input logic [63:0] dat, input int badpar);
    d_valid = 1; d_read = rd; d_dw = dw; d_addr = a; d_data = dat;
    d_apar  = ~^a   ^ (badpar == 1);
    d_dpar  = ~^dat ^ (badpar == 2);
  endtask

  task automatic req(input logic rd, input logic dw, input logic [23:0] a,
                     input logic [63:0] dat, input int badpar);
    set_req(rd, dw, a, dat, badpar);
    drive_cycle();
    clear_drive();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  // Monitor: sampled 1ns after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (mmio_bus.mmio_out_ack === 1'b1) begin
        if (q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_ack: ack=1 at cycle %0d, expected no ack", cyc);
        end else begin
          e = q.pop_front();
          chk64("ack_cycle", 64'(cyc), 64'(e.cyc));
          chk64("rd_data", mmio_bus.mmio_out_data, e.data);
          chk64("datapar", {63'h0, mmio_bus.mmio_out_datapar}, {63'h0, e.par});
          chk64("req_valid", {63'h0, algo_request_valid}, {63'h0, e.pulse});
          chk64("req_out", algo_request_out, e.req);
        end
      end else begin
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          n_vec++; n_bad++;
          $display("FAIL missing_ack: ack=0 at cycle %0d, expected ack at %0d", cyc, q[0].cyc);
          void'(q.pop_front());
        end
        chk64("idle_data", mmio_bus.mmio_out_data, 64'h0);
        chk64("idle_par", {63'h0, mmio_bus.mmio_out_datapar}, 64'h0);
        chk64("idle_req_valid", {63'h0, algo_request_valid}, 64'h0);
      end
    end
  end

  initial begin
    clear_drive();
    rstn = 1'b0;
    mmio_bus.mmio_in_valid = 0; mmio_bus.mmio_in_read = 0; mmio_bus.mmio_in_dw = 0;
    mmio_bus.mmio_in_addr = 0; mmio_bus.mmio_in_addrpar = 0;
    mmio_bus.mmio_in_data = 0; mmio_bus.mmio_in_datapar = 0;
    algo_status_valid = 0; algo_status_in = 0; error_valid = 0; error_in = 0;
    #12;
    chk64("rst_ack", {63'h0, mmio_bus.mmio_out_ack}, 64'h0);
    chk64("rst_data", mmio_bus.mmio_out_data, 64'h0);
    chk64("rst_req_out", algo_request_out, 64'h0);
    chk64("rst_req_valid", {63'h0, algo_request_valid}, 64'h0);
    idle(2);
    d_rst = 1'b1;
    idle(2);

    // Status reads, including a load that lands in the read's decode cycle
    req(1, 1, A_STATUS, 0, 0);              idle(3);
    d_sv = 1; d_sin = 64'h1; drive_cycle(); clear_drive();
    req(1, 1, A_STATUS, 0, 0);              idle(3);
    req(1, 1, A_STATUS, 0, 0);
    d_sv = 1; d_sin = 64'h2; drive_cycle(); clear_drive();
    idle(2);
    req(1, 1, A_STATUS, 0, 0);              idle(3);

    // Request register: full write, then 32-bit reads of each half and a half write
    req(0, 1, A_REQ, 64'hDEAD_BEEF_0000_0001, 0); idle(3);
    req(1, 0, 24'hFFFFFD, 0, 0);            idle(3);
    req(1, 0, A_REQ, 0, 0);                 idle(3);
    req(0, 0, 24'hFFFFFD, 64'h1234_5678_CAFE_F00D, 0); idle(3);
    req(1, 1, A_REQ, 0, 0);                 idle(3);
    req(0, 1, A_STATUS, 64'hFFFF, 0);       idle(3);
    req(1, 1, 24'h000010, 0, 0);            idle(3);

    // Error register: sticky set, write-1-to-clear, and set winning over clear
    d_ev = 1; d_ein = 64'h8; drive_cycle(); clear_drive();
    req(1, 1, A_ERR, 0, 0);                 idle(3);
    req(0, 1, A_ERR, 64'h8, 0);             idle(3);
    req(1, 1, A_ERR, 0, 0);                 idle(3);
    d_ev = 1; d_ein = 64'h8; drive_cycle(); clear_drive();
    req(0, 1, A_ERR, 64'h8, 0);
    d_ev = 1; d_ein = 64'h8; drive_cycle(); clear_drive();
    idle(2);
    req(1, 1, A_ERR, 0, 0);                 idle(3);

    // Overlapping request is dropped and flagged
    req(1, 1, A_STATUS, 0, 0);
    req(1, 1, A_REQ, 0, 0);                 idle(3);
    req(1, 1, A_ERR, 0, 0);                 idle(3);

    // Bad parity on a request write, then a read
    req(0, 1, A_REQ, 64'h0BAD_0BAD_0BAD_0BAD, 2); idle(3);
    req(0, 1, A_REQ, 64'h0BAD_0BAD_0BAD_0BAD, 1); idle(3);
    req(1, 1, A_ERR, 0, 0);                 idle(3);
    req(1, 1, A_REQ, 0, 1);                 idle(3);
    req(1, 1, A_REQ, 0, 0);                 idle(3);

    // Reset while a request is in decode: no ack for it
    req(0, 1, A_REQ, 64'h5555, 0);
    d_rst = 1'b0; drive_cycle(); d_rst = 1'b1;
    idle(3);
    req(1, 1, A_REQ, 0, 0);                 idle(3);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [23:0] a;
      int pick;
      pick = $urandom_range(0, 7);
      a = (pick < 6) ? 24'hFFFFFA + 24'(pick) : 24'($urandom);
      if ($urandom_range(0, 99) < 45)
        set_req(1'($urandom), 1'($urandom), a, {$urandom, $urandom},
                ($urandom_range(0, 99) < 8) ? int'($urandom_range(1, 2)) : 0);
      if ($urandom_range(0, 99) < 20) begin d_sv = 1; d_sin = {$urandom, $urandom}; end
      if ($urandom_range(0, 99) < 20) begin d_ev = 1; d_ein = 64'h1 << $urandom_range(0, 63); end
      drive_cycle();
      clear_drive();
    end

    idle(10);
    chk64("drain", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/afu_mmio_responder.md
Name: afu_mmio_responder

Overview:
- AFU-side MMIO responder. Decodes host MMIO reads and writes from the PSL and acknowledges each one.
- Maps three 64-bit registers:
  - ALGO_REQUEST: host writes, AFU consumes.
  - ALGO_STATUS: AFU drives, host reads.
  - ERROR_REG: AFU sets sticky bits, host reads and clears with write-1-to-clear.
- Sits between the PSL MMIO interface and AFU control, opposite the host driver's MMIO accesses.

Parameters:
- ALGO_STATUS_ADDR, 24'hFFFFFE, word address of the status register (host read-only).
- ALGO_REQUEST_ADDR, 24'hFFFFFC, word address of the request register (host read/write).
- ERROR_REG_ADDR, 24'hFFFFFA, word address of the error register (host read, write-1-to-clear).
- MMIO_ADDR_W, 24, MMIO word-address width.

Ports:
- clock  in  1  sole clock
- rstn  in  1  asynchronous active-low reset
- mmio_in_valid  in  1  one-cycle request strobe
- mmio_in_read  in  1  1=read, 0=write
- mmio_in_dw  in  1  1=64-bit access, 0=32-bit access
- mmio_in_addr  in  24  word address
- mmio_in_addrpar  in  1  odd parity over mmio_in_addr
- mmio_in_data  in  64  write data
- mmio_in_datapar  in  1  odd parity over mmio_in_data
- mmio_out_ack  out  1  one-cycle acknowledge
- mmio_out_data  out  64  read data, valid with ack
- mmio_out_datapar  out  1  odd parity over mmio_out_data
- algo_status_in  in  64  status value from AFU control
- algo_status_valid  in  1  load algo_status_in into ALGO_STATUS
- error_in  in  64  error bits from AFU (bits 61:0 used)
- error_valid  in  1  OR error_in[61:0] into ERROR_REG
- algo_request_out  out  64  current ALGO_REQUEST value
- algo_request_valid  out  1  one-cycle pulse on each host write to ALGO_REQUEST

Behaviour:
- Reset (async, rstn=0): all outputs 0, all registers 0, FSM to IDLE. Reset mid-transaction aborts it; no ack is ever issued for that request.
- FSM states IDLE -> DECODE -> ACK -> IDLE.
  - IDLE: on mmio_in_valid, capture read, dw, addr, data and parities; go to DECODE.
  - DECODE: address match; write updates take effect at the end of this cycle; read data is registered from register values as they stood at the start of this cycle.
  - ACK: mmio_out_ack=1 for exactly one cycle.
- Latency: mmio_in_valid in cycle N gives mmio_out_ack in cycle N+2, for reads and writes. Back-to-back throughput is one request per 3 cycles.
- Overlap: mmio_in_valid in DECODE or ACK is dropped (no ack) and sets ERROR_REG[63].
- 64-bit read: mmio_out_data = full register.
- 32-bit read: addr[0]=0 selects bits 31:0, addr[0]=1 selects bits 63:32; the selected word is replicated on both halves. Register match ignores addr[0] for 32-bit accesses.
- Unmapped read returns 0 and is acked. mmio_out_data returns to 0 outside the ACK cycle.
- Write to ALGO_REQUEST:
  - 64-bit write replaces the whole register; 32-bit write updates only the addressed half with data[31:0].
  - algo_request_valid pulses in the ACK cycle, with algo_request_out already updated.
- Write to ERROR_REG: write-1-to-clear on the written bits.
- Write to ALGO_STATUS or an unmapped address: acked, no effect.
- ALGO_STATUS loads algo_status_in on any cycle algo_status_valid=1, independent of MMIO traffic.
- ERROR_REG bits 61:0: sticky OR of error_in. If set and clear hit the same bit in the same cycle, set wins.

Optional Feature:
- Macro MMIO_PARITY_EN.
- Defined:
  - Captured addrpar is checked on every request; datapar is checked on writes.
  - On mismatch, the request is still acked with normal latency, any write is suppressed, reads return 0, and ERROR_REG[62] is set.
  - mmio_out_datapar = odd parity of mmio_out_data during ACK, 0 otherwise.
- Undefined: no checking, ERROR_REG[62] stays 0, mmio_out_datapar tied 0.

Test Plan:
- Reset, then 64-bit read of 24'hFFFFFE -> ack exactly 2 cycles after valid, data 0.
- algo_status_valid with 64'h1 in cycle N, then 64-bit read issued in cycle N+1 -> ack at N+3, data 64'h1. Same status load in the DECODE cycle of a read -> that read returns the old value.
- 64-bit write 64'hDEAD_BEEF_0000_0001 to 24'hFFFFFC -> algo_request_valid pulses once in the ack cycle, algo_request_out equals the written value. Then 32-bit read at 24'hFFFFFD -> data 64'hDEADBEEF_DEADBEEF.
- error_valid with bit 3 set -> read of ERROR_REG returns 64'h8. Write 64'h8 -> next read returns 0. Clear coinciding with error_valid bit 3 -> bit 3 stays set.
- Second mmio_in_valid one cycle after the first -> only one ack, and ERROR_REG[63]=1 on the next read.
- With MMIO_PARITY_EN defined: write to ALGO_REQUEST with wrong datapar -> acked, algo_request_valid stays 0, ERROR_REG[62]=1. A following read returns data with mmio_out_datapar equal to its odd parity.
